// File: rtl/mig_pkg.sv
// Shared types for the majority-inverter-graph sequential evaluator:
// width helpers, operand/node records and the controller state encoding.
package mig_pkg;

  // Widest operand index over the legal parameter range (1+16+64 slots).
  localparam int IDX_W_MAX = 7;

  function automatic int mig_idx_w(input int n_in, input int max_nodes);
    return $clog2(1 + n_in + max_nodes);
  endfunction

  function automatic int mig_opw(input int n_in, input int max_nodes);
    return mig_idx_w(n_in, max_nodes) + 1;
  endfunction

  typedef struct packed {
    logic                 cmp;
    logic [IDX_W_MAX-1:0] idx;
  } mig_opnd_t;

  typedef struct packed {
    mig_opnd_t op_a;
    mig_opnd_t op_b;
    mig_opnd_t op_c;
  } mig_node_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } mig_state_t;

endpackage

// File: rtl/mig_maj3.sv
// Three-input majority gate with an independent complement on each operand.
module mig_maj3 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic a_inv_i,
  input  logic b_inv_i,
  input  logic c_inv_i,
  output logic y_o
);

  logic a_eff;
  logic b_eff;
  logic c_eff;

  assign a_eff = a_i ^ a_inv_i;
  assign b_eff = b_i ^ b_inv_i;
  assign c_eff = c_i ^ c_inv_i;
  assign y_o   = (a_eff & b_eff) | (a_eff & c_eff) | (b_eff & c_eff);

endmodule

// File: rtl/mig_seq_eval.sv
// Sequential MIG evaluator: one majority node per clock out of a configurable
// node memory, with a job handshake in and a result handshake out.
module mig_seq_eval
  import mig_pkg::*;
#(
  parameter int  N_IN      = 4,
  parameter int  MAX_NODES = 16,
  localparam int IDX_W     = mig_idx_w(N_IN, MAX_NODES),
  localparam int OPW       = mig_opw(N_IN, MAX_NODES),
  localparam int AW        = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1,
  localparam int LW        = $clog2(MAX_NODES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [3*OPW-1:0] cfg_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_x,
  input  logic [LW-1:0]    in_len,
  input  logic [OPW-1:0]   in_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic             out_err,
  output logic             busy
);

  localparam int NV   = N_IN + 1 + MAX_NODES;
  localparam int LIMW = IDX_W_MAX + 1;

  mig_state_t          state_q, state_d;
  logic [AW-1:0]       k_q, k_d;
  logic [LW-1:0]       n_q, n_d;
  logic [OPW-1:0]      out_q, out_d;
  logic                err_q, err_d;
  logic [NV-1:0]       val_q, val_d;
  logic                out_y_q, out_y_d;
  logic                out_err_q, out_err_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                enter_done;

  logic [3*OPW-1:0]    mem_q [MAX_NODES];
  logic [MAX_NODES-1:0] mem_wr;

  function automatic mig_opnd_t widen(input logic [OPW-1:0] o);
    mig_opnd_t r;
    r.cmp = o[OPW-1];
    r.idx = IDX_W_MAX'(o[IDX_W-1:0]);
    return r;
  endfunction

  // Node memory: writable only while idle, cleared by reset.
  for (genvar gi = 0; gi < MAX_NODES; gi++) begin : g_mem
    assign mem_wr[gi] = cfg_we && (state_q == ST_IDLE) && (cfg_addr == AW'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_q[gi] <= '0;
      end else if (mem_wr[gi]) begin
        mem_q[gi] <= cfg_data;
      end
    end
  end

  // Operand fetch for the node being evaluated this cycle.
  mig_node_t       node_s;
  logic [LIMW-1:0] node_lim;
  logic            leg_a, leg_b, leg_c;
  logic            raw_a, raw_b, raw_c;
  logic            maj_y;

  always_comb begin
    node_s.op_a = widen(mem_q[k_q][3*OPW-1 -: OPW]);
    node_s.op_b = widen(mem_q[k_q][2*OPW-1 -: OPW]);
    node_s.op_c = widen(mem_q[k_q][OPW-1:0]);
    // Node k may only see const0, inputs and nodes 0..k-1.
    node_lim    = LIMW'(N_IN + 1) + LIMW'(k_q);
    leg_a       = {1'b0, node_s.op_a.idx} < node_lim;
    leg_b       = {1'b0, node_s.op_b.idx} < node_lim;
    leg_c       = {1'b0, node_s.op_c.idx} < node_lim;
    raw_a       = leg_a & val_q[node_s.op_a.idx[IDX_W-1:0]];
    raw_b       = leg_b & val_q[node_s.op_b.idx[IDX_W-1:0]];
    raw_c       = leg_c & val_q[node_s.op_c.idx[IDX_W-1:0]];
  end

  mig_maj3 u_maj3 (
    .a_i     (raw_a),
    .b_i     (raw_b),
    .c_i     (raw_c),
    .a_inv_i (leg_a & node_s.op_a.cmp),
    .b_inv_i (leg_b & node_s.op_b.cmp),
    .c_inv_i (leg_c & node_s.op_c.cmp),
    .y_o     (maj_y)
  );

  mig_opnd_t       out_op;
  logic [LIMW-1:0] out_lim;
  logic            out_legal;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    out_d       = out_q;
    err_d       = err_q;
    val_d       = val_q;
    out_y_d     = out_y_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    enter_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          val_d[0]      = 1'b0;
          val_d[N_IN:1] = in_x;
          n_d           = (in_len > LW'(MAX_NODES)) ? LW'(MAX_NODES) : in_len;
          out_d         = in_out;
          k_d           = '0;
          err_d         = 1'b0;
          in_ready_d    = 1'b0;
          busy_d        = 1'b1;
          if (n_d == '0) begin
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = ST_EVAL;
          end
        end
      end
      ST_EVAL: begin
        val_d[IDX_W'(N_IN + 1) + IDX_W'(k_q)] = maj_y;
        err_d = err_q | ~leg_a | ~leg_b | ~leg_c;
        k_d   = k_q + AW'(1);
        if (LW'(k_q) == n_q - LW'(1)) begin
          state_d    = ST_DONE;
          enter_done = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase

    // The result is taken from val_d so the final node is visible on the same edge.
    out_op    = widen(out_d);
    out_lim   = LIMW'(N_IN + 1) + LIMW'(n_d);
    out_legal = {1'b0, out_op.idx} < out_lim;
    if (enter_done) begin
      out_y_d     = out_legal & (val_d[out_op.idx[IDX_W-1:0]] ^ out_op.cmp);
      out_err_d   = err_d | ~out_legal;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      n_q         <= '0;
      out_q       <= '0;
      err_q       <= 1'b0;
      val_q       <= '0;
      out_y_q     <= 1'b0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      out_q       <= out_d;
      err_q       <= err_d;
      val_q       <= val_d;
      out_y_q     <= out_y_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_err   = out_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mig_seq_eval.sv
// Directed bench for mig_seq_eval at default parameters (N_IN=4, MAX_NODES=16):
// index 0 = const0, 1..4 = x0..x3, 5+k = node k.
module tb_mig_seq_eval;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [17:0] cfg_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_x;
  logic [4:0]  in_len;
  logic [5:0]  in_out;
  logic        out_valid;
  logic        out_ready;
  logic        out_y;
  logic        out_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mig_seq_eval dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_len    (in_len),
    .in_out    (in_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  function automatic logic [5:0] op(input logic c, input logic [4:0] idx);
    return {c, idx};
  endfunction

  function automatic logic [17:0] ent(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    return {a, b, c};
  endfunction

  task automatic cfg_write(input logic [3:0] a, input logic [17:0] d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_rdy_after"}, in_ready, 1);
    chk({tag, "_vld_after"}, out_valid, 0);
  endtask

  // Launch a job (optionally with a config write in the same cycle), measure
  // edges from accept to out_valid and check the result.
  task automatic run_job(input string tag, input logic we, input logic [3:0] wa,
                         input logic [17:0] wd, input logic [3:0] x, input logic [4:0] len,
                         input logic [5:0] oo, input int exp_lat, input logic exp_y,
                         input logic exp_err, input bit do_release);
    int lat;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1);
    cfg_we   = we;
    cfg_addr = wa;
    cfg_data = wd;
    in_valid = 1'b1;
    in_x     = x;
    in_len   = len;
    in_out   = oo;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_y"}, out_y, exp_y);
    chk({tag, "_err"}, out_err, exp_err);
    if (do_release) release_out(tag);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_x = '0; in_len = '0; in_out = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst = 1'b0;

    // n=1, node0 = maj(x0,x1,x2), x=0011 -> 1 after 2 edges
    cfg_write(4'd0, ent(op(0, 1), op(0, 2), op(0, 3)));
    run_job("n1_maj", 0, 0, 0, 4'b0011, 5'd1, op(0, 5), 2, 1'b1, 1'b0, 1'b0);
    chk("n1_busy_done", busy, 1);
    release_out("n1_maj");

    // n=0, output = ~const0
    run_job("n0_cmp", 0, 0, 0, 4'b0000, 5'd0, op(1, 0), 1, 1'b1, 1'b0, 1'b1);

    // n=2 chain: node0 = maj(x0,x1,~x2), node1 = maj(node0,x3,const0)
    cfg_write(4'd0, ent(op(0, 1), op(0, 2), op(1, 3)));
    cfg_write(4'd1, ent(op(0, 5), op(0, 4), op(0, 0)));
    run_job("n2_x1001", 0, 0, 0, 4'b1001, 5'd2, op(0, 6), 3, 1'b1, 1'b0, 1'b1);
    run_job("n2_x1000", 0, 0, 0, 4'b1000, 5'd2, op(0, 6), 3, 1'b0, 1'b0, 1'b1);

    // Hold out_ready low; a write during DONE must be dropped.
    run_job("hold", 0, 0, 0, 4'b1001, 5'd2, op(0, 6), 3, 1'b1, 1'b0, 1'b0);
    cfg_write(4'd1, ent(op(0, 0), op(0, 0), op(0, 0)));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_vld_%0d", i), out_valid, 1);
      chk($sformatf("hold_y_%0d", i), out_y, 1);
    end
    release_out("hold");
    run_job("mem_kept", 0, 0, 0, 4'b1001, 5'd2, op(0, 6), 3, 1'b1, 1'b0, 1'b1);

    // Forward reference: node0 reads node1 (stale val=1 must read as 0)
    cfg_write(4'd0, ent(op(0, 6), op(0, 1), op(0, 2)));
    cfg_write(4'd1, ent(op(0, 5), op(0, 5), op(0, 5)));
    run_job("fwd_ref", 0, 0, 0, 4'b0001, 5'd2, op(0, 6), 3, 1'b0, 1'b1, 1'b1);

    // Write and job in the same idle cycle: job sees new node0 = maj(1,1,0)
    run_job("wr_same", 1, 4'd0, ent(op(1, 0), op(1, 0), op(0, 0)), 4'b0000, 5'd1,
            op(0, 5), 2, 1'b1, 1'b0, 1'b1);

    // Output operand beyond N_IN+n
    run_job("out_oob", 0, 0, 0, 4'b0011, 5'd1, op(0, 6), 2, 1'b0, 1'b1, 1'b1);

    // Reset during an n=8 job
    for (int i = 0; i < 8; i++) cfg_write(4'(i), ent(op(1, 0), op(1, 0), op(0, 0)));
    @(negedge clk);
    in_valid = 1'b1; in_x = 4'b0000; in_len = 5'd8; in_out = op(1, 12);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_vld", out_valid, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rdy", in_ready, 1);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    chk("arst_no_pulse", out_valid, 0);
    run_job("post_n8", 0, 0, 0, 4'b0000, 5'd8, op(1, 12), 9, 1'b1, 1'b0, 1'b1);
    run_job("post_n1", 0, 0, 0, 4'b1111, 5'd1, op(0, 5), 2, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
